// File: rtl/snn_dec_pkg.sv
// ============================================================================
// snn_dec_pkg : shared types, widths and default sizes for the spike decoder
// Rev 1.0
// ============================================================================
`default_nettype none

package snn_dec_pkg;

   localparam int DEF_NUM_NEURONS = 10;
   localparam int DEF_TIMESTEPS   = 4;

   typedef enum logic [1:0] {
      ST_ACCUM = 2'd0,
      ST_SCAN  = 2'd1,
      ST_DONE  = 2'd2
   } dec_state_e;

   // clog2 that never collapses to a zero-width vector
   function automatic int width_of(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

`default_nettype wire

// File: rtl/spike_counter_bank.sv
// ============================================================================
// spike_counter_bank : per-neuron spike counters with one increment port,
// a combinational read port and a synchronous clear. Rev 1.0
// ============================================================================
`default_nettype none

module spike_counter_bank
   import snn_dec_pkg::*;
#(
   parameter int NUM_NEURONS = DEF_NUM_NEURONS,
   parameter int IDX_W       = width_of(NUM_NEURONS),
   parameter int CNT_W       = width_of(DEF_TIMESTEPS + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear_all_i,
   input  logic [IDX_W-1:0] idx_i,
   input  logic             en_i,
   input  logic             inc_i,
   input  logic [IDX_W-1:0] ridx_i,
   output logic [CNT_W-1:0] rd_cnt_o
);

   logic [CNT_W-1:0] cnt_q [NUM_NEURONS];

   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_NEURONS; i++) begin
         if (rst || clear_all_i) begin
            cnt_q[i] <= '0;
         end else if (en_i && inc_i && (idx_i == IDX_W'(i))) begin
            cnt_q[i] <= cnt_q[i] + CNT_W'(1);
         end
      end
   end

   assign rd_cnt_o = cnt_q[ridx_i];

endmodule

`default_nettype wire

// File: rtl/spike_rate_decoder.sv
// ============================================================================
// spike_rate_decoder : counts spikes per output neuron over a window of
// timesteps, then scans for the argmax and presents it on a handshake. Rev 1.0
// ============================================================================
`default_nettype none

module spike_rate_decoder
   import snn_dec_pkg::*;
#(
   parameter int NUM_NEURONS = DEF_NUM_NEURONS,
   parameter int TIMESTEPS   = DEF_TIMESTEPS,
   parameter int IDX_W       = width_of(NUM_NEURONS),
   parameter int CNT_W       = width_of(TIMESTEPS + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_valid,
   input  logic             spike_in,
   output logic             i_ready,
   output logic             o_valid,
   input  logic             o_ready,
   output logic [IDX_W-1:0] o_class,
   output logic [CNT_W-1:0] o_max_count,
   output logic             o_busy
);

   localparam int               STEP_W    = width_of(TIMESTEPS);
   localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_NEURONS - 1);
   localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(TIMESTEPS - 1);

   dec_state_e        state_q, state_d;
   logic [IDX_W-1:0]  nidx_q, nidx_d;
   logic [STEP_W-1:0] step_q, step_d;
   logic [IDX_W-1:0]  best_idx_q, best_idx_d;
   logic [CNT_W-1:0]  best_cnt_q, best_cnt_d;
   logic              o_valid_q, o_valid_d;
   logic [IDX_W-1:0]  o_class_q, o_class_d;
   logic [CNT_W-1:0]  o_cnt_q, o_cnt_d;
   logic [CNT_W-1:0]  rd_cnt;

   logic beat, last_beat, scan_last, accept;

   assign beat      = i_valid && (state_q == ST_ACCUM);
   assign last_beat = beat && (nidx_q == LAST_IDX) && (step_q == LAST_STEP);
   assign scan_last = (state_q == ST_SCAN) && (nidx_q == LAST_IDX);
   assign accept    = o_valid_q && o_ready;

   // nidx doubles as the scan index, so one read port serves both phases
   spike_counter_bank #(
      .NUM_NEURONS (NUM_NEURONS),
      .IDX_W       (IDX_W),
      .CNT_W       (CNT_W)
   ) u_bank (
      .clk         (clk),
      .rst         (rst),
      .clear_all_i (accept),
      .idx_i       (nidx_q),
      .en_i        (beat),
      .inc_i       (spike_in),
      .ridx_i      (nidx_q),
      .rd_cnt_o    (rd_cnt)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_ACCUM;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_ACCUM: if (last_beat) state_d = ST_SCAN;
         ST_SCAN:  if (scan_last) state_d = ST_DONE;
         ST_DONE:  if (accept)    state_d = ST_ACCUM;
         default:                 state_d = ST_ACCUM;
      endcase
   end

   always_comb begin
      i_ready = (state_q == ST_ACCUM);
      o_busy  = (state_q == ST_SCAN) || (state_q == ST_DONE);
   end

   always_comb begin
      nidx_d     = nidx_q;
      step_d     = step_q;
      best_idx_d = best_idx_q;
      best_cnt_d = best_cnt_q;
      o_valid_d  = o_valid_q;
      o_class_d  = o_class_q;
      o_cnt_d    = o_cnt_q;
      case (state_q)
         ST_ACCUM: begin
            if (beat) begin
               if (nidx_q == LAST_IDX) begin
                  nidx_d = '0;
                  step_d = (step_q == LAST_STEP) ? '0 : step_q + STEP_W'(1);
               end else begin
                  nidx_d = nidx_q + IDX_W'(1);
               end
            end
         end
         ST_SCAN: begin
            // strict compare keeps the lowest index on ties
            if ((nidx_q == '0) || (rd_cnt > best_cnt_q)) begin
               best_idx_d = nidx_q;
               best_cnt_d = rd_cnt;
            end
            nidx_d = scan_last ? '0 : nidx_q + IDX_W'(1);
         end
         ST_DONE: begin
            if (!o_valid_q) begin
               o_valid_d = 1'b1;
               o_class_d = best_idx_q;
               o_cnt_d   = best_cnt_q;
            end else if (o_ready) begin
               o_valid_d = 1'b0;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         nidx_q     <= '0;
         step_q     <= '0;
         best_idx_q <= '0;
         best_cnt_q <= '0;
         o_valid_q  <= 1'b0;
         o_class_q  <= '0;
         o_cnt_q    <= '0;
      end else begin
         nidx_q     <= nidx_d;
         step_q     <= step_d;
         best_idx_q <= best_idx_d;
         best_cnt_q <= best_cnt_d;
         o_valid_q  <= o_valid_d;
         o_class_q  <= o_class_d;
         o_cnt_q    <= o_cnt_d;
      end
   end

   assign o_valid     = o_valid_q;
   assign o_class     = o_class_q;
   assign o_max_count = o_cnt_q;

endmodule

`default_nettype wire

// File: doc/spike_rate_decoder.md
Name: spike_rate_decoder

Overview:
- Output-side counterpart of the LIF neuron layer. It consumes the serial spike stream that the LIF stage emits (one neuron per valid beat, for TIMESTEPS frames) and decodes it back into a classification.
- It keeps a per-neuron spike count across the window, then scans the counts for the argmax.
- It presents the winning class index and its count on a valid/ready output handshake.
- It sits at the tail of the SNN pipeline, after the final LIF layer.

Parameters:
- NUM_NEURONS, 10, output neurons per timestep (≥2).
- TIMESTEPS, 4, timesteps per inference window (≥1).
- IDX_W, $clog2(NUM_NEURONS), neuron/class index width.
- CNT_W, $clog2(TIMESTEPS+1), per-neuron spike count width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- i_valid  in  1  spike beat valid (same meaning as the LIF o_valid).
- spike_in  in  1  spike for the current neuron (the LIF spike_out).
- i_ready  out  1  decoder accepts a beat; a beat transfers when i_valid&&i_ready.
- o_valid  out  1  result valid; held until accepted.
- o_ready  in  1  downstream accepts the result.
- o_class  out  IDX_W  argmax neuron index.
- o_max_count  out  CNT_W  spike count of o_class.
- o_busy  out  1  high in SCAN or DONE.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=ACCUM; all counters and index/step counters = 0.
  - i_ready=1, o_valid=0, o_class=0, o_max_count=0, o_busy=0.
  - Reset mid-window or mid-scan discards all partial counts.
- Beat ordering:
  - Within a timestep, beats map to neurons 0..NUM_NEURONS-1 in order.
  - Timesteps run 0..TIMESTEPS-1.
  - Neuron index and step are tracked internally; there is no index input.
- ACCUM (i_ready=1):
  - On each accepted beat, cnt[nidx] += spike_in.
  - nidx wraps NUM_NEURONS-1→0 and step increments at the wrap.
  - Counts cannot exceed TIMESTEPS, so there is no overflow; the adder is CNT_W wide.
  - On the accepted beat with nidx=NUM_NEURONS-1 and step=TIMESTEPS-1, that beat's spike is still counted. Next cycle: state=SCAN, nidx=0, step=0.
- SCAN (i_ready=0, o_busy=1):
  - One counter examined per cycle, index s=0..NUM_NEURONS-1.
  - best starts at index 0 / cnt[0] on s=0.
  - For s>0, best updates only if cnt[s] > best_cnt (strict). Ties resolve to the lowest index.
  - All-zero counts give class 0, count 0.
  - After s=NUM_NEURONS-1: state=DONE.
- DONE (i_ready=0):
  - o_valid=1, with o_class/o_max_count registered from best; they are stable while o_valid=1.
  - On o_valid&&o_ready: o_valid=0 next cycle, all counters cleared, state=ACCUM, i_ready=1.
- Latency: last beat accepted at edge t → SCAN occupies edges t+1..t+NUM_NEURONS → o_valid=1 after edge t+NUM_NEURONS+1.
- Input beats offered while i_ready=0 are not consumed. Upstream must stall, since the LIF stage has no backpressure; the integration layer guarantees a gap of ≥NUM_NEURONS+2 cycles between windows.
- spike_in is ignored when i_valid=0.
- o_ready held high continuously: exactly a one-cycle o_valid pulse per window.
- All outputs are registered.

Decomposition:
- Package snn_dec_pkg:
  - state enum {ACCUM, SCAN, DONE};
  - clog2-based width helper for IDX_W/CNT_W;
  - default NUM_NEURONS/TIMESTEPS constants shared with the LIF layer wrapper.
- One sub-module, spike_counter_bank:
  - NUM_NEURONS×CNT_W register array;
  - increment port (idx, en, inc);
  - combinational read port (ridx);
  - synchronous clear_all.
- The top module holds the FSM, the index/step counters, argmax tracking and the output handshake.

Test Plan:
- NUM_NEURONS=10, TIMESTEPS=4, neuron 7 spikes every step, others silent, o_ready=1 → o_class=7, o_max_count=4, o_valid high exactly at last-beat edge+11, for one cycle.
- Neurons 2 and 5 spike 3 times each, neuron 0 spikes once → o_class=2, o_max_count=3 (tie → lowest index).
- All spikes zero → o_class=0, o_max_count=0, o_valid asserted normally.
- o_ready=0 for 5 cycles after o_valid → o_valid/o_class/o_max_count stable; i_ready=0 and extra i_valid beats not counted. Raise o_ready → accepted. A second window with neuron 9 ×2 → o_class=9, count 2 (proves clear).
- rst pulsed after 23 beats of a window, then a full window with neuron 4 ×1 → o_class=4, o_max_count=1 (no residue from the aborted window).
- i_valid gapped randomly (50% duty) with a reference-model spike pattern → the result matches a software count/argmax over 100 random windows.
